// File: rtl/menu_select_overlay_if.sv
// Video timing + colour bus passed between display pipeline stages.
interface menu_select_overlay_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/menu_select_overlay.sv
// Menu selection FSM plus a blinking highlight frame drawn over the selected slot.
// Adds one clock of latency to the whole timing/colour bus.
module menu_select_overlay #(
  parameter int unsigned MENU_RECT_X     = 411,
  parameter int unsigned MENU_RECT_Y     = 84,
  parameter int unsigned MENU_RECT_WIDTH = 200,
  parameter int unsigned SLOT_H          = 96,
  parameter int unsigned NUM_OPTS        = 3,
  parameter int unsigned INSET           = 8,
  parameter int unsigned BORDER          = 4,
  parameter int unsigned BLINK_FRAMES    = 30,
  parameter logic [11:0] FRAME_COLOR     = 12'hfff
) (
  input  logic                          clk,
  input  logic                          rst,
  menu_select_overlay_if.slave          vga_in,
  menu_select_overlay_if.master         vga_out,
  input  logic                          btn_up,
  input  logic                          btn_down,
  input  logic                          btn_enter,
  input  logic                          btn_back,
  output logic [1:0]                    selected_opt,
  output logic                          select_valid,
  output logic                          locked
);

  localparam int unsigned CntW   = $clog2(BLINK_FRAMES);
  localparam logic [1:0]  SelMax = 2'(NUM_OPTS - 1);
  localparam logic [10:0] BoxX0  = 11'(MENU_RECT_X + INSET);
  localparam logic [10:0] BoxX1  = 11'(MENU_RECT_X + MENU_RECT_WIDTH - 1 - INSET);
  localparam logic [10:0] Bord   = 11'(BORDER);

  typedef enum logic [0:0] {StBrowse, StLocked} state_e;

  state_e            state_q, state_d;
  logic [1:0]        sel_q, sel_d;
  logic [1:0]        sel_disp_q, sel_disp_d;
  logic [CntW-1:0]   frame_cnt_q, frame_cnt_d;
  logic              blink_on_q, blink_on_d;
  logic [3:0]        btn_prev_q;
  logic              vsync_prev_q;
  logic              select_valid_q, select_valid_d;
  logic              locked_q;

  logic [10:0] hcount_q, vcount_q;
  logic        hsync_q, vsync_q, hblnk_q, vblnk_q;
  logic [11:0] rgb_q, rgb_d;

  logic up_e, down_e, enter_e, back_e, vsync_rise;
  logic [10:0] top, box_y0, box_y1;
  logic in_box, near_edge, in_frame;

  assign up_e       = btn_up    & ~btn_prev_q[0];
  assign down_e     = btn_down  & ~btn_prev_q[1];
  assign enter_e    = btn_enter & ~btn_prev_q[2];
  assign back_e     = btn_back  & ~btn_prev_q[3];
  assign vsync_rise = vga_in.vsync & ~vsync_prev_q;

  // Frame geometry follows the displayed slot, not the live selection.
  always_comb begin
    top       = 11'(MENU_RECT_Y) + 11'(sel_disp_q) * 11'(SLOT_H);
    box_y0    = top + 11'(INSET);
    box_y1    = top + 11'(SLOT_H - 1 - INSET);
    in_box    = (vga_in.hcount >= BoxX0) && (vga_in.hcount <= BoxX1) &&
                (vga_in.vcount >= box_y0) && (vga_in.vcount <= box_y1);
    near_edge = (vga_in.hcount < BoxX0 + Bord) || (vga_in.hcount > BoxX1 - Bord) ||
                (vga_in.vcount < box_y0 + Bord) || (vga_in.vcount > box_y1 - Bord);
    in_frame  = in_box && near_edge;
  end

  always_comb begin
    state_d        = state_q;
    sel_d          = sel_q;
    select_valid_d = 1'b0;
    unique case (state_q)
      StBrowse: begin
        if (enter_e) begin
          state_d        = StLocked;
          select_valid_d = 1'b1;
        end else if (up_e && !down_e) begin
          sel_d = (sel_q == 2'd0) ? SelMax : sel_q - 2'd1;
        end else if (down_e && !up_e) begin
          sel_d = (sel_q == SelMax) ? 2'd0 : sel_q + 2'd1;
        end
      end
      StLocked: begin
        if (back_e) state_d = StBrowse;
      end
      default: state_d = StBrowse;
    endcase

    frame_cnt_d = frame_cnt_q;
    blink_on_d  = blink_on_q;
    if (sel_d != sel_q) begin
      frame_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if (vsync_rise) begin
      if (frame_cnt_q == CntW'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end

    sel_disp_d = vsync_rise ? sel_q : sel_disp_q;

    rgb_d = vga_in.rgb;
    if (!vga_in.hblnk && !vga_in.vblnk && in_frame &&
        (blink_on_q || state_q == StLocked)) begin
      rgb_d = FRAME_COLOR;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= StBrowse;
      sel_q          <= '0;
      sel_disp_q     <= '0;
      frame_cnt_q    <= '0;
      blink_on_q     <= 1'b1;
      btn_prev_q     <= '0;
      vsync_prev_q   <= 1'b0;
      select_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      hcount_q       <= '0;
      vcount_q       <= '0;
      hsync_q        <= 1'b0;
      vsync_q        <= 1'b0;
      hblnk_q        <= 1'b0;
      vblnk_q        <= 1'b0;
      rgb_q          <= '0;
    end else begin
      state_q        <= state_d;
      sel_q          <= sel_d;
      sel_disp_q     <= sel_disp_d;
      frame_cnt_q    <= frame_cnt_d;
      blink_on_q     <= blink_on_d;
      btn_prev_q     <= {btn_back, btn_enter, btn_down, btn_up};
      vsync_prev_q   <= vga_in.vsync;
      select_valid_q <= select_valid_d;
      locked_q       <= (state_d == StLocked);
      hcount_q       <= vga_in.hcount;
      vcount_q       <= vga_in.vcount;
      hsync_q        <= vga_in.hsync;
      vsync_q        <= vga_in.vsync;
      hblnk_q        <= vga_in.hblnk;
      vblnk_q        <= vga_in.vblnk;
      rgb_q          <= rgb_d;
    end
  end

  assign vga_out.hcount = hcount_q;
  assign vga_out.vcount = vcount_q;
  assign vga_out.hsync  = hsync_q;
  assign vga_out.vsync  = vsync_q;
  assign vga_out.hblnk  = hblnk_q;
  assign vga_out.vblnk  = vblnk_q;
  assign vga_out.rgb    = rgb_q;
  assign selected_opt   = sel_q;
  assign select_valid   = select_valid_q;
  assign locked         = locked_q;

endmodule
